code_loader: RTL and testbench

- Byte-stream writer for the CPU's instruction store; the producer side of the byte-addressed, big-endian code memory that the fetch path reads by PC.
- Accepts a length-framed byte stream from a host/boot source over a valid/ready handshake.
- Packs every 4 bytes into one 32-bit instruction word and issues one write per word at consecutive word-aligned byte addresses.
- Holds the CPU stalled until the image is fully loaded.

---
 rtl/code_loader_pkg.sv | 17 +
 rtl/code_loader_byte_packer.sv | 42 ++++
 rtl/code_loader.sv | 120 ++++++++++++
 tb/tb_code_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/code_loader_pkg.sv
// Shared definitions between the code loader and the instruction store.
package code_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    localparam int WORD_BYTES = 4;
    localparam int IMEM_BYTES = 68;

endpackage

// File: rtl/code_loader_byte_packer.sv
// Big-endian 4-to-1 byte packer; first byte lands in word bits 31:24.
// word_full_o is combinational: high on the shift that completes a word.
module code_loader_byte_packer
    import code_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (shift_i) begin
            word_d = {word_q[23:0], byte_i};
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/code_loader.sv
// Loads a length-framed byte stream into the instruction store one word per write,
// holding the CPU until the image is complete. Write strobe 1 cycle after a word's last byte.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int ADDR_W    = 32
)(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [15:0]       words_loaded_o
);

    localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       len_full;
    logic [17:0]       len_bytes;
    logic              xfer;
    logic              pk_clear, pk_shift, pk_full;
    logic [31:0]       pk_word;

    // Ready is a pure function of state so it never loops back through valid.
    assign byte_ready_o = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA);
    assign xfer         = byte_ready_o && byte_valid_i;
    assign len_full     = {len_q[15:8], byte_i};
    assign len_bytes    = {len_full, 2'b00};
    assign pk_shift     = xfer && (state_q == ST_DATA);

    code_loader_byte_packer u_packer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (pk_clear),
        .shift_i     (pk_shift),
        .byte_i      (byte_i),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        words_d  = words_q;
        addr_d   = addr_q;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d  = ST_LEN_HI;
                    words_d  = '0;
                    addr_d   = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_i;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_i;
                    if (len_full == 16'd0)
                        state_d = ST_DONE;
                    else if (len_bytes > MEM_LIMIT)
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (pk_full)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(WORD_BYTES);
                words_d = words_q + 16'd1;
                state_d = (words_d == len_q) ? ST_DONE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            words_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            addr_q  <= addr_d;
        end
    end

    assign wr_en_o        = (state_q == ST_WRITE);
    assign wr_addr_o      = addr_q;
    assign wr_data_o      = pk_word;
    assign words_loaded_o = words_q;
    assign done_o         = (state_q == ST_DONE);
    assign error_o        = (state_q == ST_ERR);
    assign cpu_hold_o     = (state_q != ST_DONE);

endmodule

// File: tb/tb_code_loader.sv
// Randomized bench for code_loader with a queue scoreboard fed by an image-level model.
module tb_code_loader;

    localparam int MEM_BYTES = 68;
    localparam int ADDR_W    = 32;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              start_i;
    logic              byte_valid_i;
    logic [7:0]        byte_i;
    logic              byte_ready_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic              cpu_hold_o;
    logic              done_o;
    logic              error_o;
    logic [15:0]       words_loaded_o;

    int tests_run = 0;
    int failures  = 0;

    logic [7:0]  img[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] last_addr;
    logic [31:0] mon_addr, mon_data;

    code_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .byte_valid_i   (byte_valid_i),
        .byte_i         (byte_i),
        .byte_ready_o   (byte_ready_o),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .cpu_hold_o     (cpu_hold_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clk_i) begin
        if (!reset_i && wr_en_o) begin
            last_addr = wr_addr_o;
            if (exp_addr_q.size() == 0) begin
                tests_run++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr_o, wr_data_o);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                check("wr_addr", wr_addr_o, mon_addr);
                check("wr_data", wr_data_o, mon_data);
            end
        end
    end

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int waited;
        if (gappy) begin
            while ($urandom_range(0, 1) == 1) begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
                @(negedge clk_i);
            end
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        waited       = 0;
        while (!byte_ready_o && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (waited >= 50) begin
            tests_run++;
            failures++;
            $display("FAIL ready_timeout: got byte_ready_o=0 for 50 cycles, expected 1");
        end else begin
            @(negedge clk_i);
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic run_load(input int len_v, input int send_n, input bit gappy,
                            input bit mid_start, input bit do_check);
        bit ok;
        int exp_words;
        ok        = (len_v * 4 <= MEM_BYTES);
        exp_words = ok ? len_v : 0;
        for (int w = 0; w < exp_words; w++) begin
            exp_addr_q.push_back(32'(w * 4));
            exp_data_q.push_back({img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]});
        end
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        send_byte(8'(len_v >> 8), gappy);
        send_byte(8'(len_v), gappy);
        for (int i = 0; i < send_n; i++) begin
            if (mid_start && i == 1) begin
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
            send_byte(img[i], gappy);
        end
        if (do_check) begin
            repeat (3) @(negedge clk_i);
            check("done_o", 32'(done_o), 32'(ok));
            check("error_o", 32'(error_o), 32'(!ok));
            check("cpu_hold_o", 32'(cpu_hold_o), 32'(!ok));
            check("byte_ready_o_end", 32'(byte_ready_o), 32'd0);
            check("words_loaded_o", 32'(words_loaded_o), 32'(exp_words));
            check("pending_writes", 32'(exp_addr_q.size()), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len_r;
        bit gap_r;
        reset_i      = 1'b1;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        repeat (3) @(negedge clk_i);
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_wr_addr", wr_addr_o, 32'd0);
        check("rst_wr_data", wr_data_o, 32'd0);
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_words", 32'(words_loaded_o), 32'd0);
        check("rst_hold", 32'(cpu_hold_o), 32'd1);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", 32'(byte_ready_o), 32'd0);

        // Single fixed word.
        img.delete();
        img.push_back(8'hE0); img.push_back(8'h81); img.push_back(8'h40); img.push_back(8'h01);
        run_load(1, 4, 1'b0, 1'b0, 1'b1);

        // Fill the store exactly.
        fill_random(68);
        run_load(17, 68, 1'b0, 1'b0, 1'b1);
        check("last_addr_full", last_addr, 32'h40);

        // One word too long, then recover.
        run_load(18, 0, 1'b0, 1'b0, 1'b1);
        fill_random(4);
        run_load(1, 4, 1'b0, 1'b0, 1'b1);

        // Same image gapless and gappy with an ignored start pulse.
        fill_random(8);
        run_load(2, 8, 1'b0, 1'b0, 1'b1);
        run_load(2, 8, 1'b1, 1'b1, 1'b1);

        // Zero length.
        run_load(0, 0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of the second word.
        fill_random(12);
        run_load(3, 6, 1'b0, 1'b0, 1'b0);
        check("pending_before_rst", 32'(exp_addr_q.size()), 32'd2);
        reset_i = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wr_en_o), 32'd0);
        check("midrst_wr_addr", wr_addr_o, 32'd0);
        check("midrst_words", 32'(words_loaded_o), 32'd0);
        check("midrst_ready", 32'(byte_ready_o), 32'd0);
        check("midrst_hold", 32'(cpu_hold_o), 32'd1);
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        fill_random(8);
        run_load(2, 8, 1'b0, 1'b0, 1'b1);

        // Random loads across the legal/illegal boundary.
        for (int k = 0; k < 6; k++) begin
            len_r = $urandom_range(0, 19);
            gap_r = 1'($urandom_range(0, 1));
            fill_random(4 * len_r);
            run_load(len_r, (len_r * 4 <= MEM_BYTES) ? 4 * len_r : 0, gap_r, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
